gcm_output_buffer: RTL and testbench

- Stage directly downstream of the final GCM pipeline stage.
- Captures the bit-reversed ciphertext blocks and the authentication tag produced by that stage.
- Buffers the ciphertext blocks in a FIFO and presents them to the host on a valid/ready stream, ciphertext first, then exactly one tag per message.
- Decouples host back-pressure from the free-running pipeline; the pipeline itself cannot stall.

---
 rtl/gcm_pkg.sv | 8 +
 rtl/gcm_block_fifo.sv | 63 ++++++
 rtl/gcm_output_buffer.sv | 107 ++++++++++
 tb/tb_gcm_output_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared types for the GCM output stage
package gcm_pkg;
  localparam int BLOCK_W = 128;

  typedef logic [0:BLOCK_W-1] block_t;

  typedef enum logic {S_STREAM, S_TAG} out_state_e;
endpackage

// File: rtl/gcm_block_fifo.sv
// rtl/gcm_block_fifo.sv - ciphertext block FIFO with head read from registered storage
module gcm_block_fifo
  import gcm_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  block_t        wdata,
  output block_t        head,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          empty_next,
  output logic          push_ok
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  block_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_next;
  logic            full;
  logic            pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a block when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign empty_next = (count_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Gated so stale storage never leaks out after a reset.
  assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/gcm_output_buffer.sv
// rtl/gcm_output_buffer.sv - buffers ciphertext and tag from the final GCM stage onto a host stream
module gcm_output_buffer
  import gcm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  block_t           i_cipher_text,
  input  logic             i_cp_ready,
  input  block_t           i_tag,
  input  logic             i_tag_ready,
  output block_t           o_data,
  output logic             o_valid,
  output logic             o_is_tag,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_block_count,
  output logic             o_overflow,
  output logic             o_busy
);
  localparam int AW = $clog2(DEPTH);

  out_state_e    state;
  out_state_e    state_next;
  block_t        head;
  block_t        tag_reg;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_empty_next;
  logic          push_ok;
  logic          ct_pop;
  logic          tag_pop;
  logic          tag_pending;
  logic          tag_prev;
  logic          tag_rise;

  assign ct_pop   = (state == S_STREAM) & ~fifo_empty & i_out_ready;
  assign tag_pop  = (state == S_TAG) & i_out_ready;
  assign tag_rise = i_tag_ready & ~tag_prev;

  gcm_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (i_cp_ready),
    .pop        (ct_pop),
    .wdata      (i_cipher_text),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .push_ok    (push_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_STREAM;
    else        state <= state_next;
  end

  // The tag is only presented once every block of its message has left.
  always_comb begin
    state_next = state;
    o_valid    = 1'b0;
    o_is_tag   = 1'b0;
    o_data     = '0;
    case (state)
      S_STREAM: begin
        o_valid = ~fifo_empty;
        o_data  = head;
        if (tag_pending && fifo_empty_next) state_next = S_TAG;
      end
      S_TAG: begin
        o_valid  = 1'b1;
        o_is_tag = 1'b1;
        o_data   = tag_reg;
        if (i_out_ready) state_next = S_STREAM;
      end
      default: state_next = S_STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_prev      <= 1'b0;
      tag_reg       <= '0;
      tag_pending   <= 1'b0;
      o_overflow    <= 1'b0;
      o_block_count <= '0;
    end else begin
      tag_prev <= i_tag_ready;
      if (tag_rise) begin
        tag_reg     <= i_tag;
        tag_pending <= 1'b1;
      end else if (tag_pop) begin
        tag_pending <= 1'b0;
      end
      if ((i_cp_ready && !push_ok) || (tag_rise && tag_pending && !tag_pop))
        o_overflow <= 1'b1;
      if (tag_pop)
        o_block_count <= '0;
      else if (ct_pop && (o_block_count != '1))
        o_block_count <= o_block_count + 1'b1;
    end
  end

  assign o_busy = (fifo_count != '0) | tag_pending;
endmodule

// File: tb/tb_gcm_output_buffer.sv
// tb/tb_gcm_output_buffer.sv - self-checking bench for gcm_output_buffer
module tb_gcm_output_buffer;
  import gcm_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  block_t           cipher_text = '0;
  logic             cp_ready = 1'b0;
  block_t           tag = '0;
  logic             tag_ready = 1'b0;
  logic             out_ready = 1'b0;
  block_t           data;
  logic             valid;
  logic             is_tag;
  logic [CNT_W-1:0] block_count;
  logic             overflow;
  logic             busy;

  always #5 clk = ~clk;

  gcm_output_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cipher_text (cipher_text),
    .i_cp_ready    (cp_ready),
    .i_tag         (tag),
    .i_tag_ready   (tag_ready),
    .o_data        (data),
    .o_valid       (valid),
    .o_is_tag      (is_tag),
    .i_out_ready   (out_ready),
    .o_block_count (block_count),
    .o_overflow    (overflow),
    .o_busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a queue of accepted blocks plus the pending tag.
  block_t mq[$];
  block_t m_tag = '0;
  bit     m_pend = 0, m_in_tag = 0, m_ovf = 0, m_prev = 0;
  int     m_bcount = 0;
  block_t log_d[$];
  bit     log_t[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_tag = '0; m_pend = 0; m_in_tag = 0; m_ovf = 0; m_prev = 0; m_bcount = 0;
    end else begin : upd
      bit pop, tpop, push, rise;
      if (valid && out_ready) begin
        log_d.push_back(data);
        log_t.push_back(is_tag);
      end
      pop  = !m_in_tag && (mq.size() > 0) && out_ready;
      tpop = m_in_tag && out_ready;
      push = cp_ready && ((mq.size() < DEPTH) || pop);
      rise = tag_ready && !m_prev;
      m_prev = tag_ready;
      if (pop) begin
        void'(mq.pop_front());
        m_bcount++;
      end
      if (push) mq.push_back(cipher_text);
      else if (cp_ready) m_ovf = 1;
      if (m_in_tag) m_in_tag = !out_ready;
      else          m_in_tag = m_pend && (mq.size() == 0);
      if (tpop) m_bcount = 0;
      if (rise) begin
        if (m_pend && !tpop) m_ovf = 1;
        m_tag  = tag;
        m_pend = 1;
      end else if (tpop) begin
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin : cmp
      block_t e_data;
      e_data = m_in_tag ? m_tag : ((mq.size() > 0) ? mq[0] : '0);
      chk("cmp_valid", valid, m_in_tag || (mq.size() > 0));
      chk("cmp_is_tag", is_tag, m_in_tag);
      chk("cmp_data", data, e_data);
      chk("cmp_busy", busy, (mq.size() > 0) || m_pend);
      chk("cmp_overflow", overflow, m_ovf);
      chk("cmp_block_count", block_count, 128'(m_bcount));
    end
  end

  task automatic step(input bit cp, input block_t ct, input bit tr, input block_t t, input bit rdy);
    cp_ready = cp; cipher_text = ct; tag_ready = tr; tag = t; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, '0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(0);
    idle(0);
    rst_n = 1'b1;
    log_d.delete();
    log_t.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam block_t TAG_A5 = {16{8'hA5}};
  localparam block_t TAG_B  = {4{32'hC0FFEE11}};

  initial begin
    int n;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_is_tag", is_tag, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_block_count", block_count, 0);
    do_reset();

    // Three blocks then a tag.
    step(1, 128'h1, 0, '0, 1);
    step(1, 128'h2, 0, '0, 1);
    step(1, 128'h3, 0, '0, 1);
    step(0, '0, 1, TAG_A5, 1);
    for (int i = 0; i < 10 && !is_tag; i++) idle(0);
    chk("t1_tag_seen", is_tag, 1);
    chk("t1_tag_data", data, TAG_A5);
    chk("t1_count_before_tag", block_count, 3);
    idle(1);
    chk("t1_count_after_tag", block_count, 0);
    chk("t1_idle_valid", valid, 0);
    chk("t1_log_size", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("t1_out0", log_d[0], 128'h1);
      chk("t1_out1", log_d[1], 128'h2);
      chk("t1_out2", log_d[2], 128'h3);
      chk("t1_out3", log_d[3], TAG_A5);
      chk("t1_tags", {log_t[0], log_t[1], log_t[2], log_t[3]}, 4'b0001);
    end

    // Overflow: nine pushes into eight entries with the host stalled.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 128'(16 + i), 0, '0, 0);
    chk("t2_overflow", overflow, 1);
    chk("t2_head", data, 128'd16);
    for (int i = 0; i < 10; i++) idle(1);
    chk("t2_log_size", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) chk("t2_order", log_d[i], 128'(16 + i));

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 128'(32 + i), 0, '0, 0);
    chk("t3_no_overflow_full", overflow, 0);
    log_d.delete(); log_t.delete();
    step(1, 128'd40, 0, '0, 1);
    chk("t3_overflow_after_pushpop", overflow, 0);
    chk("t3_head_after_pushpop", data, 128'd33);
    for (int i = 0; i < 10; i++) idle(1);
    chk("t3_log_size", log_d.size(), 9);
    for (int i = 0; i < 9 && i < log_d.size(); i++) chk("t3_order", log_d[i], 128'(32 + i));

    // Tag level held five cycles with two blocks buffered.
    do_reset();
    step(1, 128'd50, 0, '0, 0);
    step(1, 128'd51, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, TAG_B, 1);
    for (int i = 0; i < 6; i++) idle(1);
    n = 0;
    foreach (log_t[i]) if (log_t[i]) n++;
    chk("t4_tag_count", n, 1);
    chk("t4_log_size", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("t4_first", log_d[0], 128'd50);
      chk("t4_second", log_d[1], 128'd51);
      chk("t4_tag_last", {log_t[2], log_d[2]}, {1'b1, TAG_B});
    end

    // Host stall: outputs hold.
    do_reset();
    step(1, 128'd77, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      chk("t5_stall_valid", valid, 1);
      chk("t5_stall_data", data, 128'd77);
      chk("t5_stall_is_tag", is_tag, 0);
    end
    idle(1);
    idle(1);

    // Asynchronous reset mid-message.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 128'(90 + i), 0, '0, 0);
    step(0, '0, 1, TAG_B, 0);
    idle(0);
    chk("t6_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", valid, 0);
    chk("t6_async_is_tag", is_tag, 0);
    chk("t6_async_data", data, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_count", block_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t6_post_reset_valid", valid, 0);
    end
    step(1, 128'd99, 0, '0, 0);
    chk("t6_new_push_valid", valid, 1);
    chk("t6_new_push_data", data, 128'd99);
    idle(1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
